// File: rtl/tune_ctl_pkg.sv
// Shared types and sizing helpers for the tuner serial loader.
package tune_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } tune_state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DIV_DEF    = 4;
    localparam int unsigned LE_CYC_DEF = 2;

    // Bits needed for a counter that holds values 0..max_val-1 (at least 1 bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned PH_W_DEF  = cnt_w(max2(DIV_DEF, LE_CYC_DEF));
    localparam int unsigned BIT_W_DEF = cnt_w(DATA_W_DEF);

endpackage

// File: rtl/tune_phase_cnt.sv
// Loadable down-counter with a zero flag, times the sclk half-periods and the sle window.
module tune_phase_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/tune_serial_loader.sv
// Shifts the tune PIO word out as a 3-wire synthesizer load (sclk/sdata/sle), MSB first,
// with a one-deep pending buffer and a sticky overrun flag.
module tune_serial_loader
    import tune_ctl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIV    = DIV_DEF,
    parameter int unsigned LE_CYC = LE_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tune_word,
    input  logic              tune_wr,
    input  logic              ovr_clr,
    output logic              sclk,
    output logic              sdata,
    output logic              sle,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned PH_W  = cnt_w(max2(DIV, LE_CYC));
    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam logic [PH_W-1:0]  DIV_LD   = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  LE_LD    = PH_W'(LE_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tune_state_e       state;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] hold;
    logic              pend;
    logic [BIT_W-1:0]  bitcnt;

    logic              ph_load_c;
    logic [PH_W-1:0]   ph_val_c;
    logic              ph_zero_c;
    logic              consume_c;
    logic              pend_nxt_c;
    logic              idle_nxt_c;

    tune_phase_cnt #(.W(PH_W)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load_c),
        .load_val (ph_val_c),
        .zero_c   (ph_zero_c)
    );

    // Phase counter reload: DIV-1 for each half-period, LE_CYC-1 entering the latch window.
    always_comb begin
        ph_load_c = 1'b0;
        ph_val_c  = DIV_LD;
        case (state)
            ST_LOAD:     ph_load_c = 1'b1;
            ST_SHIFT_LO: ph_load_c = ph_zero_c;
            ST_SHIFT_HI: begin
                ph_load_c = ph_zero_c;
                if (bitcnt == '0) begin
                    ph_val_c = LE_LD;
                end
            end
            default: ;
        endcase
    end

    // Pending-word bookkeeping: a word is consumed when IDLE or a finishing LATCH picks it up.
    always_comb begin
        consume_c  = pend & ((state == ST_IDLE) | ((state == ST_LATCH) & ph_zero_c));
        pend_nxt_c = tune_wr | (pend & ~consume_c);
        idle_nxt_c = ((state == ST_IDLE) | ((state == ST_LATCH) & ph_zero_c)) & ~pend;
    end

    // Holding register, pending flag, overrun (set beats clear) and registered busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold    <= '0;
            pend    <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (tune_wr) begin
                hold <= tune_word;
            end
            pend <= pend_nxt_c;
            busy <= pend_nxt_c | ~idle_nxt_c;
            if (tune_wr & pend & ~consume_c) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Frame FSM with registered serial outputs; sdata only moves while sclk is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            sr     <= '0;
            bitcnt <= '0;
            sclk   <= 1'b0;
            sdata  <= 1'b0;
            sle    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        state  <= ST_LOAD;
                        sr     <= hold;
                        bitcnt <= BIT_LAST;
                        sdata  <= hold[DATA_W-1];
                    end
                end
                ST_LOAD: begin
                    state <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (ph_zero_c) begin
                        state <= ST_SHIFT_HI;
                        sclk  <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (ph_zero_c) begin
                        sclk <= 1'b0;
                        if (bitcnt == '0) begin
                            state <= ST_LATCH;
                            sle   <= 1'b1;
                            sdata <= 1'b0;
                        end else begin
                            state  <= ST_SHIFT_LO;
                            sr     <= sr << 1;
                            sdata  <= sr[DATA_W-2];
                            bitcnt <= bitcnt - BIT_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (ph_zero_c) begin
                        sle  <= 1'b0;
                        done <= 1'b1;
                        if (pend) begin
                            state  <= ST_LOAD;
                            sr     <= hold;
                            bitcnt <= BIT_LAST;
                            sdata  <= hold[DATA_W-1];
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tune_serial_loader.sv
// Directed bench for tune_serial_loader: default instance plus a DIV=1/LE_CYC=1/8-bit instance.
module tb_tune_serial_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] tune_word;
    logic        tune_wr, ovr_clr;
    logic        sclk, sdata, sle, busy, done, overrun;

    logic [7:0]  tw1;
    logic        wr1, oc1;
    logic        sclk1, sdata1, sle1, busy1, done1, overrun1;

    tune_serial_loader dut (
        .clk(clk), .reset(reset), .tune_word(tune_word), .tune_wr(tune_wr), .ovr_clr(ovr_clr),
        .sclk(sclk), .sdata(sdata), .sle(sle), .busy(busy), .done(done), .overrun(overrun)
    );

    tune_serial_loader #(.DATA_W(8), .DIV(1), .LE_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .tune_word(tw1), .tune_wr(wr1), .ovr_clr(oc1),
        .sclk(sclk1), .sdata(sdata1), .sle(sle1), .busy(busy1), .done(done1), .overrun(overrun1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Frame monitor on the default instance, sampled 1 time unit after each rising clk.
    int          cyc = 0;
    logic [31:0] rx = '0;
    int          nbits = 0, hi_run = 0, hi_bad = 0, sle_run = 0;
    int          done_cnt = 0, done_cyc = 0;
    logic        prev_sclk = 1'b0, prev_sle = 1'b0, prev_sdata = 1'b0;
    logic [31:0] frames[$];
    int          fbits[$];
    int          slens[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            rx = '0; nbits = 0; hi_run = 0; sle_run = 0;
            prev_sclk = 1'b0; prev_sle = 1'b0; prev_sdata = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                rx = {rx[30:0], sdata};
                nbits++;
            end
            if (sclk && prev_sclk && (sdata != prev_sdata)) hi_bad++;
            if (sclk) hi_run++;
            else if (prev_sclk) begin
                if (hi_run != 4) hi_bad++;
                hi_run = 0;
            end
            if (sle) sle_run++;
            else if (prev_sle) begin
                frames.push_back(rx);
                fbits.push_back(nbits);
                slens.push_back(sle_run);
                rx = '0; nbits = 0; sle_run = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_sclk = sclk; prev_sle = sle; prev_sdata = sdata;
        end
    end

    function automatic logic [31:0] frame_at(input int i);
        return (i < frames.size()) ? frames[i] : 'x;
    endfunction

    function automatic logic [31:0] fbits_at(input int i);
        return (i < fbits.size()) ? 32'(fbits[i]) : 'x;
    endfunction

    function automatic logic [31:0] slen_at(input int i);
        return (i < slens.size()) ? 32'(slens[i]) : 'x;
    endfunction

    task automatic write_word(input logic [31:0] w);
        @(negedge clk);
        tune_word = w;
        tune_wr   = 1'b1;
        @(negedge clk);
        tune_wr   = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    // {sclk, sdata, sle, done} per cycle after LOAD entry for word 8'h96 with DIV=1, LE_CYC=1.
    logic [3:0] exp5 [0:18] = '{
        4'b0100,                        // LOAD, MSB=1 on sdata
        4'b0100, 4'b1100,               // bit 7 = 1
        4'b0000, 4'b1000,               // bit 6 = 0
        4'b0000, 4'b1000,               // bit 5 = 0
        4'b0100, 4'b1100,               // bit 4 = 1
        4'b0000, 4'b1000,               // bit 3 = 0
        4'b0100, 4'b1100,               // bit 2 = 1
        4'b0100, 4'b1100,               // bit 1 = 1
        4'b0000, 4'b1000,               // bit 0 = 0
        4'b0010,                        // latch window
        4'b0001                         // done pulse
    };

    int d0, f0, e0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tune_word = '0; tune_wr = 1'b0; ovr_clr = 1'b0;
        tw1 = '0; wr1 = 1'b0; oc1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {26'd0, sclk, sdata, sle, done, busy, overrun}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single frame, default timing
        d0 = done_cnt; f0 = frames.size();
        write_word(32'hA5C3_0F81);
        e0 = cyc;
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(d0 + 1, 400, "t1_done");
        check("t1_latency", 32'(done_cyc - e0), 32'd260);
        check("t1_nframes", 32'(frames.size() - f0), 32'd1);
        check("t1_frame", frame_at(f0), 32'hA5C3_0F81);
        check("t1_bits", fbits_at(f0), 32'd32);
        check("t1_sle_len", slen_at(f0), 32'd2);
        check("t1_sclk_shape", 32'(hi_bad), 32'd0);
        @(negedge clk);
        check("t1_idle", {28'd0, busy, done, sle, sclk}, 32'd0);

        // Second word written mid-frame is queued, back-to-back
        d0 = done_cnt; f0 = frames.size();
        write_word(32'h0000_0001);
        repeat (50) @(negedge clk);
        write_word(32'h8000_0000);
        wait_done(d0 + 2, 800, "t2_done");
        check("t2_frame0", frame_at(f0), 32'h0000_0001);
        check("t2_frame1", frame_at(f0 + 1), 32'h8000_0000);
        check("t2_overrun", 32'(overrun), 32'd0);

        // Overwriting a pending word flags overrun; set beats clear
        d0 = done_cnt; f0 = frames.size();
        write_word(32'd1);
        repeat (20) @(negedge clk);
        write_word(32'd2);
        check("t3_no_ovr_yet", 32'(overrun), 32'd0);
        repeat (20) @(negedge clk);
        write_word(32'd3);
        check("t3_ovr_set", 32'(overrun), 32'd1);
        wait_done(d0 + 2, 800, "t3_done");
        check("t3_nframes", 32'(frames.size() - f0), 32'd2);
        check("t3_frame0", frame_at(f0), 32'd1);
        check("t3_frame1", frame_at(f0 + 1), 32'd3);
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 32'd0);
        d0 = done_cnt; f0 = frames.size();
        write_word(32'd4);
        repeat (20) @(negedge clk);
        write_word(32'd5);
        repeat (20) @(negedge clk);
        tune_word = 32'd6; tune_wr = 1'b1; ovr_clr = 1'b1;
        @(negedge clk);
        tune_wr = 1'b0; ovr_clr = 1'b0;
        check("t3_set_beats_clr", 32'(overrun), 32'd1);
        wait_done(d0 + 2, 800, "t3b_done");
        check("t3b_frame0", frame_at(f0), 32'd4);
        check("t3b_frame1", frame_at(f0 + 1), 32'd6);

        // Asynchronous reset during bit 10 (sclk high, sdata=1); overrun still set from above
        write_word(32'h0060_0000);
        for (int i = 0; i < 400 && !(nbits == 10 && sclk); i++) @(negedge clk);
        check("t4_reached_bit10", 32'(nbits), 32'd10);
        check("t4_pre_state", {29'd0, sclk, sdata, overrun}, 32'h7);
        d0 = done_cnt; f0 = frames.size();
        #2 reset = 1'b1;
        #1 check("t4_async_clear", {26'd0, sclk, sdata, sle, done, busy, overrun}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_no_sle", 32'(frames.size() - f0), 32'd0);
        write_word(32'hCAFE_F00D);
        wait_done(d0 + 1, 400, "t4_done");
        check("t4_frame", frame_at(f0), 32'hCAFE_F00D);
        check("t4_bits", fbits_at(f0), 32'd32);

        // Write on the exact IDLE->LOAD edge queues without overrun
        d0 = done_cnt; f0 = frames.size();
        @(negedge clk);
        tune_word = 32'h0F0F_0F0F; tune_wr = 1'b1;
        @(negedge clk);
        tune_word = 32'hF00F_5AA5;
        @(negedge clk);
        tune_wr = 1'b0;
        check("t6_no_ovr", 32'(overrun), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        wait_done(d0 + 2, 800, "t6_done");
        check("t6_frame0", frame_at(f0), 32'h0F0F_0F0F);
        check("t6_frame1", frame_at(f0 + 1), 32'hF00F_5AA5);
        check("t6_ovr_end", 32'(overrun), 32'd0);
        check("sclk_shape_all", 32'(hi_bad), 32'd0);

        // Minimal timing instance, cycle-exact trace
        @(negedge clk);
        tw1 = 8'h96; wr1 = 1'b1;
        @(negedge clk);
        wr1 = 1'b0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            check($sformatf("t5_cyc%0d", c), {28'd0, sclk1, sdata1, sle1, done1}, {28'd0, exp5[c]});
        end
        check("t5_idle", {30'd0, busy1, overrun1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
